wb_burst_arbiter: RTL and testbench

Round-robin Wishbone arbiter sharing the single core-side memory port (`m_wbd_*`) among N requesters, e.g. I$ refill, D$ refill and the uncached "others" path. Grant is registered and held for a whole multi-beat burst. It releases on the last ack, when the requester abandons the cycle, or when a watchdog times out waiting for an ack. Sits between the cache/LSU masters and the SoC Wishbone interconnect.

---
 rtl/wb_burst_arbiter_if.sv | 66 ++++++
 rtl/wb_burst_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_wb_burst_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_burst_arbiter_if.sv
// -----------------------------------------------------------------------------
// Bus bundles for wb_burst_arbiter.
//
// wb_req_if : requester side, N flattened Wishbone slots.
//   master modport - the cache/LSU requesters (drive *_i, receive *_o)
//   slave  modport - the arbiter
//   s_wbd_dat_i/adr_i [32*N], s_wbd_sel_i/bl_i [4*N], s_wbd_we/cyc/stb_i [N]
//   s_wbd_dat_o [32] (broadcast), s_wbd_ack_o/err_o [N]
//
// wb_mem_if : single core-side memory port towards the SoC interconnect.
//   master modport - the arbiter
//   slave  modport - the interconnect
//   m_wbd_dat_o/adr_o [32], m_wbd_sel_o [4], m_wbd_bl_o [10],
//   m_wbd_we/cyc/stb/bry_o [1], m_wbd_dat_i [32], m_wbd_ack_i [1]
// -----------------------------------------------------------------------------
interface wb_req_if #(
    parameter int N = 3
);
    logic [32*N-1:0] s_wbd_dat_i;
    logic [32*N-1:0] s_wbd_adr_i;
    logic [4*N-1:0]  s_wbd_sel_i;
    logic [4*N-1:0]  s_wbd_bl_i;
    logic [N-1:0]    s_wbd_we_i;
    logic [N-1:0]    s_wbd_cyc_i;
    logic [N-1:0]    s_wbd_stb_i;
    logic [31:0]     s_wbd_dat_o;
    logic [N-1:0]    s_wbd_ack_o;
    logic [N-1:0]    s_wbd_err_o;

    modport master (
        output s_wbd_dat_i, s_wbd_adr_i, s_wbd_sel_i, s_wbd_bl_i,
               s_wbd_we_i, s_wbd_cyc_i, s_wbd_stb_i,
        input  s_wbd_dat_o, s_wbd_ack_o, s_wbd_err_o
    );

    modport slave (
        input  s_wbd_dat_i, s_wbd_adr_i, s_wbd_sel_i, s_wbd_bl_i,
               s_wbd_we_i, s_wbd_cyc_i, s_wbd_stb_i,
        output s_wbd_dat_o, s_wbd_ack_o, s_wbd_err_o
    );
endinterface

interface wb_mem_if;
    logic [31:0] m_wbd_dat_o;
    logic [31:0] m_wbd_adr_o;
    logic [3:0]  m_wbd_sel_o;
    logic [9:0]  m_wbd_bl_o;
    logic        m_wbd_we_o;
    logic        m_wbd_cyc_o;
    logic        m_wbd_stb_o;
    logic        m_wbd_bry_o;
    logic [31:0] m_wbd_dat_i;
    logic        m_wbd_ack_i;

    modport master (
        output m_wbd_dat_o, m_wbd_adr_o, m_wbd_sel_o, m_wbd_bl_o,
               m_wbd_we_o, m_wbd_cyc_o, m_wbd_stb_o, m_wbd_bry_o,
        input  m_wbd_dat_i, m_wbd_ack_i
    );

    modport slave (
        input  m_wbd_dat_o, m_wbd_adr_o, m_wbd_sel_o, m_wbd_bl_o,
               m_wbd_we_o, m_wbd_cyc_o, m_wbd_stb_o, m_wbd_bry_o,
        output m_wbd_dat_i, m_wbd_ack_i
    );
endinterface

// File: rtl/wb_burst_arbiter.sv
// -----------------------------------------------------------------------------
// wb_burst_arbiter
//
// Round-robin arbiter sharing one Wishbone memory port among N requesters.
// The grant is registered and held for a whole burst; it is released on the
// last ack, when the owner drops cyc, or when the ack watchdog expires (the
// owner then sees a one-cycle err pulse).
//
// Ports:
//   clk      in   sole clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   s_wbd    wb_req_if.slave   requester slots (muxed in, ack/err routed out)
//   m_wbd    wb_mem_if.master  shared memory port
//   grant_o  out  [N] one-hot registered grant, zero when idle
//   busy_o   out  high while a burst owns the port
// -----------------------------------------------------------------------------
module wb_burst_arbiter #(
    parameter int N              = 3,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    wb_req_if.slave       s_wbd,
    wb_mem_if.master      m_wbd,
    output logic [N-1:0]  grant_o,
    output logic          busy_o
);

    localparam int             IW       = (N > 1) ? $clog2(N) : 1;
    localparam bit             WD_ON    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] WD_MAX   = '1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     grant;
    logic [IW-1:0]    last;
    logic [3:0]       beats_left;
    logic [CNT_W-1:0] wdog;
    logic [N-1:0]     err_q;

    logic [N-1:0]     req;
    logic             win_valid;
    logic [IW-1:0]    win_idx;
    logic [N-1:0]     win_oh;
    logic [3:0]       win_bl;
    logic             cur_cyc;
    logic             ack_in;
    logic             last_beat;
    logic             timeout_hit;
    logic             abort;

    assign req         = s_wbd.s_wbd_stb_i & s_wbd.s_wbd_cyc_i;
    assign ack_in      = m_wbd.m_wbd_ack_i;
    assign cur_cyc     = |(grant & s_wbd.s_wbd_cyc_i);
    assign last_beat   = (beats_left == 4'd1);
    assign timeout_hit = WD_ON && (wdog >= WD_LIMIT);
    // Timeout only fires while the owner still holds cyc and no ack arrived;
    // an abandon or a completing ack takes precedence and reports no err.
    assign abort       = (state == BUSY) && cur_cyc && !ack_in && timeout_hit;

    // Round-robin search starting one past the previous winner.
    always_comb begin
        logic [IW-1:0] cand;
        // NOTE: every variable gets a default before any conditional write,
        // otherwise the combinational block infers a latch.
        cand      = '0;
        win_valid = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
        if (win_valid) begin
            win_oh[win_idx] = 1'b1;
        end
        win_bl = s_wbd.s_wbd_bl_i[4*win_idx +: 4];
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; release priority is abandon, last ack, timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!cur_cyc || (ack_in && last_beat) || abort) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, round-robin pointer, beat counter, watchdog and err pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: all control registers are reset; the design holds no
        // storage arrays, so nothing is left to power up undefined.
        if (!reset_n) begin
            grant      <= '0;
            last       <= IW'(N - 1);
            beats_left <= '0;
            wdog       <= '0;
            err_q      <= '0;
        end else begin
            err_q <= abort ? grant : '0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant      <= win_oh;
                        last       <= win_idx;
                        beats_left <= (win_bl == 4'd0) ? 4'd1 : win_bl;
                        wdog       <= '0;
                    end
                end
                BUSY: begin
                    if (ack_in) begin
                        beats_left <= beats_left - 4'd1;
                        wdog       <= '0;
                    end else if (WD_ON && (wdog != WD_MAX)) begin
                        wdog <= wdog + CNT_W'(1);
                    end
                    if (state_nxt == IDLE) begin
                        grant <= '0;
                    end
                end
                default: grant <= '0;
            endcase
        end
    end

    // Outputs: the memory port is a grant-gated mux of the owner's inputs,
    // so an all-zero grant (idle or reset) forces every field to zero.
    always_comb begin
        busy_o             = (state == BUSY);
        grant_o            = grant;
        m_wbd.m_wbd_dat_o  = '0;
        m_wbd.m_wbd_adr_o  = '0;
        m_wbd.m_wbd_sel_o  = '0;
        m_wbd.m_wbd_bl_o   = '0;
        m_wbd.m_wbd_we_o   = 1'b0;
        m_wbd.m_wbd_cyc_o  = 1'b0;
        m_wbd.m_wbd_stb_o  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                m_wbd.m_wbd_dat_o = s_wbd.s_wbd_dat_i[32*i +: 32];
                m_wbd.m_wbd_adr_o = s_wbd.s_wbd_adr_i[32*i +: 32];
                m_wbd.m_wbd_sel_o = s_wbd.s_wbd_sel_i[4*i +: 4];
                m_wbd.m_wbd_bl_o  = {6'b0, s_wbd.s_wbd_bl_i[4*i +: 4]};
                m_wbd.m_wbd_we_o  = s_wbd.s_wbd_we_i[i];
                m_wbd.m_wbd_cyc_o = s_wbd.s_wbd_cyc_i[i];
                m_wbd.m_wbd_stb_o = s_wbd.s_wbd_stb_i[i];
            end
        end
        m_wbd.m_wbd_bry_o = m_wbd.m_wbd_stb_o;
        s_wbd.s_wbd_dat_o = m_wbd.m_wbd_dat_i;
        s_wbd.s_wbd_ack_o = grant & {N{ack_in}};
        s_wbd.s_wbd_err_o = err_q;
    end

endmodule

// File: tb/tb_wb_burst_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for wb_burst_arbiter (N=3, TIMEOUT_CYCLES=8).
// A transaction-level reference model (owner slot, beats remaining, quiet
// cycles, round-robin pointer) predicts every output each cycle. Directed
// scenarios add explicit timing/ordering checks; a random phase follows.
// Inputs change 1 ns after the rising edge, outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_wb_burst_arbiter;

    localparam int N = 3;
    localparam int T = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] grant_o;
    logic         busy_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_owner = -1;
    int m_left  = 0;
    int m_quiet = 0;
    int m_ptr   = N - 1;
    int m_err   = -1;

    always #5 clk = ~clk;

    wb_req_if #(.N(N)) req_if ();
    wb_mem_if          mem_if ();

    wb_burst_arbiter #(
        .N              (N),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_wbd   (req_if),
        .m_wbd   (mem_if),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_slot(input int i, input bit cyc, input bit stb, input logic [3:0] bl);
        req_if.s_wbd_cyc_i[i]         = cyc;
        req_if.s_wbd_stb_i[i]         = stb;
        req_if.s_wbd_we_i[i]          = 1'($urandom);
        req_if.s_wbd_bl_i[4*i +: 4]   = bl;
        req_if.s_wbd_adr_i[32*i +: 32] = $urandom;
        req_if.s_wbd_dat_i[32*i +: 32] = $urandom;
        req_if.s_wbd_sel_i[4*i +: 4]  = 4'($urandom);
    endtask

    function automatic bit slot_req(input int i);
        return req_if.s_wbd_cyc_i[i] & req_if.s_wbd_stb_i[i];
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_left  = 0;
        m_quiet = 0;
        m_ptr   = N - 1;
        m_err   = -1;
    endtask

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_edge();
        int nerr;
        nerr = -1;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (m_owner < 0 && slot_req(c)) begin
                    m_owner = c;
                    m_ptr   = c;
                    m_left  = (req_if.s_wbd_bl_i[4*c +: 4] == 0) ? 1 : int'(req_if.s_wbd_bl_i[4*c +: 4]);
                    m_quiet = 0;
                end
            end
        end else if (!req_if.s_wbd_cyc_i[m_owner]) begin
            m_owner = -1;
        end else if (mem_if.m_wbd_ack_i) begin
            if (m_left == 1) begin
                m_owner = -1;
            end else begin
                m_left  = m_left - 1;
                m_quiet = 0;
            end
        end else if (T > 0 && m_quiet >= T) begin
            nerr    = m_owner;
            m_owner = -1;
        end else begin
            m_quiet = m_quiet + 1;
        end
        m_err = nerr;
    endtask

    // Compare every DUT output with the model's prediction for this cycle.
    task automatic compare_all();
        logic [N-1:0] eg, eack, eerr;
        logic [31:0]  eadr, edat;
        logic [3:0]   esel;
        logic [9:0]   ebl;
        logic         ewe, ecyc, estb;
        eg = '0; eack = '0; eerr = '0; eadr = '0; edat = '0;
        esel = '0; ebl = '0; ewe = 1'b0; ecyc = 1'b0; estb = 1'b0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            eadr = req_if.s_wbd_adr_i[32*m_owner +: 32];
            edat = req_if.s_wbd_dat_i[32*m_owner +: 32];
            esel = req_if.s_wbd_sel_i[4*m_owner +: 4];
            ebl  = {6'b0, req_if.s_wbd_bl_i[4*m_owner +: 4]};
            ewe  = req_if.s_wbd_we_i[m_owner];
            ecyc = req_if.s_wbd_cyc_i[m_owner];
            estb = req_if.s_wbd_stb_i[m_owner];
            if (mem_if.m_wbd_ack_i) eack[m_owner] = 1'b1;
        end
        if (m_err >= 0) eerr[m_err] = 1'b1;
        check("grant",  64'(grant_o), 64'(eg));
        check("busy",   64'(busy_o), 64'(m_owner >= 0));
        check("m_stb",  64'(mem_if.m_wbd_stb_o), 64'(estb));
        check("m_bry",  64'(mem_if.m_wbd_bry_o), 64'(estb));
        check("m_cyc",  64'(mem_if.m_wbd_cyc_o), 64'(ecyc));
        check("m_we",   64'(mem_if.m_wbd_we_o), 64'(ewe));
        check("m_adr",  64'(mem_if.m_wbd_adr_o), 64'(eadr));
        check("m_dat",  64'(mem_if.m_wbd_dat_o), 64'(edat));
        check("m_sel",  64'(mem_if.m_wbd_sel_o), 64'(esel));
        check("m_bl",   64'(mem_if.m_wbd_bl_o), 64'(ebl));
        check("s_ack",  64'(req_if.s_wbd_ack_o), 64'(eack));
        check("s_err",  64'(req_if.s_wbd_err_o), 64'(eerr));
        check("s_dat",  64'(req_if.s_wbd_dat_o), 64'(mem_if.m_wbd_dat_i));
    endtask

    task automatic tick_sample();
        @(negedge clk);
        compare_all();
    endtask

    task automatic tick_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        tick_sample();
        tick_edge();
    endtask

    // Ends 1 ns after an idle rising edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        for (int i = 0; i < N; i++) set_slot(i, 1'b0, 1'b0, 4'd0);
        mem_if.m_wbd_ack_i = 1'b0;
        mem_if.m_wbd_dat_i = '0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] rr_exp [12];
        logic [N-1:0] bh_exp [9];
        bit           bh_ack [9];
        int           ack_cnt, ack2_cnt, err_cnt, stb_rise, err_c;

        rr_exp = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd0, 3'd4, 3'd0, 3'd1, 3'd0, 3'd2, 3'd0, 3'd4};
        bh_exp = '{3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd4};
        bh_ack = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset values.
        do_reset();
        tick_sample();
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_busy",  64'(busy_o), 64'd0);
        tick_edge();

        // Reset mid-burst: outputs clear immediately, slot 0 wins first after.
        do_reset();
        set_slot(0, 1'b1, 1'b1, 4'd1);
        step();
        tick_sample();
        check("rstmid_pre_stb", 64'(mem_if.m_wbd_stb_o), 64'd1);
        reset_n = 1'b0;
        #1;
        check("rstmid_grant", 64'(grant_o), 64'd0);
        check("rstmid_busy",  64'(busy_o), 64'd0);
        check("rstmid_stb",   64'(mem_if.m_wbd_stb_o), 64'd0);
        check("rstmid_cyc",   64'(mem_if.m_wbd_cyc_o), 64'd0);
        check("rstmid_adr",   64'(mem_if.m_wbd_adr_o), 64'd0);
        check("rstmid_bl",    64'(mem_if.m_wbd_bl_o), 64'd0);
        check("rstmid_err",   64'(req_if.s_wbd_err_o), 64'd0);
        model_reset();
        set_slot(1, 1'b1, 1'b1, 4'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset_n = 1'b1;
        tick_edge();
        tick_sample();
        check("rstmid_first_win", 64'(grant_o), 64'd1);
        check("rstmid_post_err",  64'(req_if.s_wbd_err_o), 64'd0);
        tick_edge();

        // Round-robin fairness with single-beat same-cycle acks.
        do_reset();
        for (int i = 0; i < N; i++) set_slot(i, 1'b1, 1'b1, 4'd1);
        mem_if.m_wbd_ack_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick_sample();
            check("rr_grant", 64'(grant_o), 64'(rr_exp[c]));
            tick_edge();
            for (int i = 0; i < N; i++) set_slot(i, 1'b1, 1'b1, 4'd1);
        end

        // Burst hold: slot 1 bl=4 keeps the port until its 4th ack.
        do_reset();
        set_slot(1, 1'b1, 1'b1, 4'd4);
        set_slot(2, 1'b1, 1'b1, 4'd1);
        ack_cnt = 0;
        ack2_cnt = 0;
        for (int c = 0; c < 9; c++) begin
            mem_if.m_wbd_ack_i = bh_ack[c];
            tick_sample();
            check("bh_grant", 64'(grant_o), 64'(bh_exp[c]));
            if (req_if.s_wbd_ack_o[1]) ack_cnt++;
            if (req_if.s_wbd_ack_o[2]) ack2_cnt++;
            tick_edge();
        end
        check("bh_slot1_acks", 64'(ack_cnt), 64'd4);
        check("bh_slot2_acks", 64'(ack2_cnt), 64'd0);

        // bl=0 behaves as a single beat.
        do_reset();
        set_slot(2, 1'b1, 1'b1, 4'd0);
        mem_if.m_wbd_ack_i = 1'b1;
        step();
        tick_sample();
        check("bl0_grant", 64'(grant_o), 64'd4);
        check("bl0_ack",   64'(req_if.s_wbd_ack_o), 64'd4);
        tick_edge();
        set_slot(2, 1'b0, 1'b0, 4'd0);
        tick_sample();
        check("bl0_released", 64'(busy_o), 64'd0);
        check("bl0_idle_ack", 64'(req_if.s_wbd_ack_o), 64'd0);
        tick_edge();

        // Watchdog: no ack ever arrives for slot 0.
        do_reset();
        set_slot(0, 1'b1, 1'b1, 4'd2);
        set_slot(1, 1'b1, 1'b1, 4'd1);
        mem_if.m_wbd_ack_i = 1'b0;
        err_cnt = 0;
        stb_rise = -1;
        err_c = -1;
        for (int c = 0; c < 13; c++) begin
            tick_sample();
            if (stb_rise < 0 && mem_if.m_wbd_stb_o) stb_rise = c;
            if (req_if.s_wbd_err_o[0]) begin
                err_cnt++;
                err_c = c;
                check("to_err_grant", 64'(grant_o), 64'd0);
            end
            if (c == 11) check("to_next_grant", 64'(grant_o), 64'd2);
            tick_edge();
        end
        check("to_err_pulses", 64'(err_cnt), 64'd1);
        check("to_err_delay",  64'(err_c - stb_rise), 64'(T + 1));

        // Abandon after 2 acks; a stray ack in IDLE reaches nobody.
        do_reset();
        set_slot(1, 1'b1, 1'b1, 4'd4);
        err_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            mem_if.m_wbd_ack_i = (c == 1 || c == 2 || c == 4);
            if (c == 3) set_slot(1, 1'b0, 1'b0, 4'd4);
            tick_sample();
            if (req_if.s_wbd_err_o != '0) err_cnt++;
            if (c == 3) check("ab_grant_held", 64'(grant_o), 64'd2);
            if (c == 4) begin
                check("ab_released",  64'(busy_o), 64'd0);
                check("ab_stray_ack", 64'(req_if.s_wbd_ack_o), 64'd0);
            end
            tick_edge();
        end
        check("ab_no_err", 64'(err_cnt), 64'd0);

        // Random traffic against the model; the second half starves acks
        // so the watchdog fires regularly.
        do_reset();
        for (int n = 0; n < 2400; n++) begin
            for (int i = 0; i < N; i++) begin
                bit cyc;
                cyc = ($urandom % 16) != 0;
                set_slot(i, cyc, cyc && (($urandom % 4) != 0), 4'($urandom));
            end
            mem_if.m_wbd_dat_i = $urandom;
            if (n < 1200) mem_if.m_wbd_ack_i = ($urandom % 2) == 0;
            else          mem_if.m_wbd_ack_i = ($urandom % 12) == 0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
